bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the double-dabble (shift-and-add-3) algorithm. It sits directly upstream of the per-digit 7-segment decoders on the DE1-SoC. It converts a binary value into six BCD nibbles, one per HEX display, plus per-digit leading-zero blank flags. It uses a start/busy/done handshake and holds the last result stable between conversions.

Parameters:
IN_W, 20, width of the binary input; must satisfy 2^IN_W > 10^DIGITS - 1.
DIGITS, 6, number of BCD output digits (one per HEX display).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
value  input  IN_W  binary operand; sampled on the edge that accepts start.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd/blank/ovf update.
ovf  output  1  value exceeded 10^DIGITS-1 and was saturated; held with the result.
bcd  output  4*DIGITS  BCD result; digit i in bits [4i+3:4i], digit 0 least significant.
blank  output  DIGITS  blank[i]=1 means digit i is a leading zero; blank[0] is always 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, ovf=0, bcd=0, blank={DIGITS-1{1},0}; internal shift register and counter cleared.
- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1 at an edge: compare value against MAX = 10^DIGITS-1.
  - value > MAX: load MAX into the binary shift field and set internal ovf_q=1. Otherwise load value and set ovf_q=0.
  - Clear the BCD field, set cnt=0 and busy=1, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Every BCD nibble >= 5 first gets +3 (combinational).
  - Then the concatenated {bcd_field, bin_field} shifts left by 1, and cnt increments.
  - When cnt reaches IN_W-1 on this edge (the IN_W-th shift), go to DONE.
- DONE, one cycle:
  - Output registers bcd, ovf and blank load from the internal fields; done=1 for this cycle only; busy=0.
  - Return to IDLE on the next edge.
- Latency: start accepted at edge t0 → busy=1 from t0. Outputs update and done=1 after edge t0+IN_W+1 (21 cycles at default). busy=0 in the same cycle as done.
- Back-to-back: start may be asserted in the cycle done is high. It is accepted on the next edge (IDLE), giving a throughput of one conversion per IN_W+2 cycles.
- start while busy: ignored, no queuing; value changes during busy have no effect.
- Outputs bcd/blank/ovf change only on the DONE transition; they are stable otherwise.
- blank computation:
  - blank[DIGITS-1]=1 iff digit DIGITS-1 is 0.
  - For i in 1..DIGITS-2: blank[i] = blank[i+1] & (digit i == 0).
  - blank[0]=0.
- Reset mid-conversion: the conversion is aborted immediately. No done pulse occurs, and outputs return to reset values (not the previous result).
- Arithmetic: the BCD field is 4*DIGITS bits and the bin field is IN_W bits. The add-3 never overflows a nibble because the pre-add value is at most 9.

Decomposition:
- Package bin_to_bcd_pkg: DIGITS and IN_W defaults, the MAX constant (10^DIGITS-1), and a state_t enum {IDLE, SHIFT, DONE}.
- One natural combinational sub-module, bcd_add3: 4-bit in, 4-bit out, adds 3 when the input is >= 5. It is instantiated DIGITS times per iteration via generate.

Test Plan:
1. Reset, then start with value=0 → after 21 cycles done=1; bcd=24'h000000, blank=6'b111110, ovf=0.
2. value=123456 → bcd=24'h123456, blank=6'b000000, ovf=0; busy high for exactly 21 cycles; done high for exactly 1 cycle.
3. value=999999 → bcd=24'h999999, ovf=0. Then value=1048575 → bcd=24'h999999, ovf=1. Then value=42 → bcd=24'h000042, blank=6'b111100, ovf cleared to 0.
4. Start with value=500; pulse start with value=777 at cycle 5 of the conversion → the second request is ignored; result is 24'h000500. Assert start in the done cycle with value=7 → the second conversion completes to 24'h000007.
5. Start value=654321; assert rst for 1 cycle at cycle 10 → busy=0 and bcd=0 immediately; no done pulse. A new start then converts correctly.
6. Randomised sweep of 1000 values in 0..2^20-1 against a reference model (decimal digits of min(value, 999999)) → all match, including the blank and ovf outputs.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   IN_W_DEF / DIGITS_DEF : default operand width and digit count
//   pow10_m1()            : 10^n - 1, the largest value n decimal digits hold
//   MAX_DEF               : saturation limit for the default digit count
//   state_t               : converter FSM states
// ----------------------------------------------------------------------------
package bin_to_bcd_pkg;

    localparam int IN_W_DEF   = 20;
    localparam int DIGITS_DEF = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic longint pow10_m1(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

    localparam longint MAX_DEF = pow10_m1(DIGITS_DEF);

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// ----------------------------------------------------------------------------
// bcd_add3
// One double-dabble correction cell: a BCD nibble of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
//   din  : current BCD nibble (0..9)
//   dout : corrected nibble (din >= 5 ? din + 3 : din); never exceeds 12
// ----------------------------------------------------------------------------
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble binary-to-BCD converter feeding the HEX displays.
// One shift per cycle; the last result is held until the next conversion.
//   clk, rst : clock, asynchronous active-high reset
//   start    : conversion request, accepted only when idle
//   value    : binary operand, captured with an accepted start
//   busy     : conversion in progress (start edge through the shift phase)
//   done     : one-cycle pulse in the cycle the outputs take the new result
//   ovf      : operand exceeded 10^DIGITS-1 and was saturated
//   bcd      : BCD digits, digit i in bits [4i+3:4i]
//   blank    : leading-zero flags per digit; blank[0] is always 0
//
// Handshake: start is sampled on a rising edge only while the FSM is IDLE;
// requests during busy are dropped, not queued. done and the busy falling
// edge coincide, and start may be raised in the done cycle for back-to-back
// conversions.
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       value,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W + 1) : 1;

    localparam logic [IN_W-1:0]   MAX_VAL     = IN_W'(pow10_m1(DIGITS));
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(IN_W - 1);
    localparam logic [DIGITS-1:0] BLANK_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    // Working fields of the iteration and the held output registers.
    state_t             state_q,     state_d;
    logic [IN_W-1:0]    bin_q,       bin_d;
    logic [BCD_W-1:0]   bcd_f_q,     bcd_f_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               ovf_f_q,     ovf_f_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               ovf_out_q,   ovf_out_d;
    logic [BCD_W-1:0]   bcd_out_q,   bcd_out_d;
    logic [DIGITS-1:0]  blank_out_q, blank_out_d;

    // Add-3 correction on every digit, then the combined left shift.
    logic [BCD_W-1:0]      bcd_adj;
    logic [BCD_W+IN_W-1:0] shift_w;
    logic [DIGITS-1:0]     blank_calc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_f_q[4*g +: 4]),
            .dout (bcd_adj[4*g +: 4])
        );
    end

    assign shift_w = {bcd_adj, bin_q} << 1;

    // Leading-zero flags ripple down from the most significant digit; the
    // least significant digit is always shown so zero displays as "0".
    always_comb begin
        logic lz_run;
        blank_calc = '0;
        lz_run     = (bcd_f_q[4*(DIGITS-1) +: 4] == 4'd0);
        blank_calc[DIGITS-1] = lz_run;
        for (int i = DIGITS - 2; i >= 1; i--) begin
            lz_run        = lz_run & (bcd_f_q[4*i +: 4] == 4'd0);
            blank_calc[i] = lz_run;
        end
        blank_calc[0] = 1'b0;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        bcd_f_d     = bcd_f_q;
        cnt_d       = cnt_q;
        ovf_f_d     = ovf_f_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        ovf_out_d   = ovf_out_q;
        bcd_out_d   = bcd_out_q;
        blank_out_d = blank_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    // Saturate out-of-range operands so the result is the
                    // largest displayable value rather than wrapped digits.
                    if (value > MAX_VAL) begin
                        bin_d   = MAX_VAL;
                        ovf_f_d = 1'b1;
                    end else begin
                        bin_d   = value;
                        ovf_f_d = 1'b0;
                    end
                    bcd_f_d = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                bcd_f_d = shift_w[BCD_W+IN_W-1:IN_W];
                bin_d   = shift_w[IN_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                bcd_out_d   = bcd_f_q;
                blank_out_d = blank_calc;
                ovf_out_d   = ovf_f_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_q       <= '0;
            bcd_f_q     <= '0;
            cnt_q       <= '0;
            ovf_f_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_out_q   <= 1'b0;
            bcd_out_q   <= '0;
            blank_out_q <= BLANK_RESET;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            bcd_f_q     <= bcd_f_d;
            cnt_q       <= cnt_d;
            ovf_f_q     <= ovf_f_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ovf_out_q   <= ovf_out_d;
            bcd_out_q   <= bcd_out_d;
            blank_out_q <= blank_out_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ovf   = ovf_out_q;
    assign bcd   = bcd_out_q;
    assign blank = blank_out_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Bench for bin_to_bcd_seq. A reference model computes each result from the
// decimal digits of min(value, 999999) and tracks the accept/complete timing
// with a simple countdown; a compare process checks every cycle.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int IN_W   = 20;
    localparam int DIGITS = 6;
    localparam int LAT    = IN_W + 1;

    // Result packed as {ovf, blank[5:0], bcd[23:0]}.
    typedef logic [30:0] res_t;
    localparam res_t RESET_RES = 31'h3E000000;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [IN_W-1:0]   value;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0] blank;

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    bin_to_bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd   (bcd),
        .blank (blank)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic res_t ref_result(input logic [IN_W-1:0] v);
        int unsigned n;
        int unsigned p;
        logic        o;
        logic [23:0] b;
        logic [5:0]  bl;
        o = (v > 20'd999999);
        n = o ? 999999 : int'(v);
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            b[4*i +: 4] = 4'((n / p) % 10);
            bl[i]       = (i != 0) && (n < p);
            p           = p * 10;
        end
        return {o, bl, b};
    endfunction

    logic m_busy;
    logic m_done;
    int   m_left;
    res_t m_out;
    res_t exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_left <= 0;
            m_out  <= RESET_RES;
            exp_q.delete();
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_left <= LAT;
                    exp_q.push_back(ref_result(value));
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_left <= 0;
                if (exp_q.size() > 0) m_out <= exp_q.pop_front();
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("result", {1'b0, ovf, blank, bcd}, {1'b0, m_out});
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (inputs change on the falling edge)
    // ------------------------------------------------------------------
    task automatic run_conv(input logic [IN_W-1:0] v, input res_t lit, input string name);
        int nb;
        bit seen;
        nb   = 0;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        value = v;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            value = IN_W'($urandom());
            if (busy) nb++;
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check(name, {1'b0, ovf, blank, bcd}, {1'b0, lit});
            check({name, "_busy_len"}, 32'(nb), 32'(LAT));
        end
    endtask

    task automatic wait_done(input string name, input res_t lit);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        else       check(name, {1'b0, ovf, blank, bcd}, {1'b0, lit});
    endtask

    function automatic logic [IN_W-1:0] pick_value();
        logic [IN_W-1:0] edges [8];
        edges[0] = 20'd0;      edges[1] = 20'd9;
        edges[2] = 20'd10;     edges[3] = 20'd99999;
        edges[4] = 20'd100000; edges[5] = 20'd999999;
        edges[6] = 20'd1000000; edges[7] = 20'd1048575;
        if ($urandom_range(0, 7) == 0) return edges[$urandom_range(0, 7)];
        return IN_W'($urandom_range(0, (1 << IN_W) - 1));
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int ndone;
        int ncyc;

        rst   = 1'b1;
        start = 1'b0;
        value = '0;

        // Pin the model with hand-computed results.
        check("model_123456", {1'b0, ref_result(20'd123456)},  32'h00123456);
        check("model_ovf",    {1'b0, ref_result(20'd1048575)}, 32'h40999999);
        check("model_42",     {1'b0, ref_result(20'd42)},      32'h3C000042);
        check("model_0",      {1'b0, ref_result(20'd0)},       32'h3E000000);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_result", {1'b0, ovf, blank, bcd}, {1'b0, RESET_RES});
        check("reset_busy",   32'(busy), 32'd0);
        check("reset_done",   32'(done), 32'd0);
        check_en = 1'b1;

        // Directed conversions.
        run_conv(20'd0,       31'h3E000000, "zero");
        run_conv(20'd123456,  31'h00123456, "v123456");
        run_conv(20'd999999,  31'h00999999, "v999999");
        run_conv(20'd1048575, 31'h40999999, "saturate");
        run_conv(20'd42,      31'h3C000042, "v42");

        // Start during busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start = 1'b1;
        value = 20'd500;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        value = 20'd777;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignored_start", 31'h38000500);
        start = 1'b1;
        value = 20'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("back_to_back", 31'h3E000007);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start = 1'b1;
        value = 20'd654321;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_bcd",  {1'b0, ovf, blank, bcd}, {1'b0, RESET_RES});
        @(posedge clk);
        #2 rst = 1'b0;
        begin
            int nd;
            nd = 0;
            repeat (30) begin
                @(negedge clk);
                if (done) nd++;
            end
            check("midrst_no_done", 32'(nd), 32'd0);
        end
        run_conv(20'd100000, 31'h00100000, "after_reset");

        // Randomised sweep, including random requests while busy.
        ndone = 0;
        ncyc  = 0;
        while (ndone < 1000 && ncyc < 40000) begin
            @(negedge clk);
            ncyc++;
            if (done) ndone++;
            start = ($urandom_range(0, 3) == 0);
            value = pick_value();
        end
        check("sweep_count", 32'(ndone >= 1000), 32'd1);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
